// File: rtl/mem_access_unit.sv
// Load/store unit between a decoded memory command and a 32-bit word memory.
// Doubles take two beats; byte and word loads are extended into a 64-bit result.
module mem_access_unit #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [1:0]  memwrite,
    input  logic        memread,
    input  logic [2:0]  readtype,
    input  logic [31:0] addr,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    // Handshake: mem_req is the valid and mem_ack the ready. A beat transfers on
    // a rising edge with both high; until then the beat fields hold steady, and
    // mem_ack seen without mem_req has no effect.

    typedef enum logic [1:0] {IDLE = 2'd0, ACC_LO = 2'd1, ACC_HI = 2'd2, RESP = 2'd3} state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_WORD = 2'd1;
    localparam logic [1:0] SZ_DBL  = 2'd2;

    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [63:0]   wdata_q, wdata_d;
    logic          write_q, write_d;
    logic [1:0]    size_q, size_d;
    logic          signed_q, signed_d;
    logic          err_q, err_d;
    logic [31:0]   lo_q, lo_d;
    logic [63:0]   rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic       is_store, start, req_bad, req_signed;
    logic [1:0] req_size;
    logic       beat_ack, timeout;
    logic [7:0] lane_byte;
    logic [31:0] lane_shift;
    logic [31:0] base_addr;

    // Command decode; a store wins when memwrite and memread arrive together.
    always_comb begin
        is_store   = (memwrite != 2'b00);
        start      = req_valid && (is_store || memread);
        req_size   = SZ_WORD;
        req_signed = 1'b0;
        if (is_store) begin
            case (memwrite)
                2'b10:   req_size = SZ_BYTE;
                2'b11:   req_size = SZ_DBL;
                default: req_size = SZ_WORD;
            endcase
        end else begin
            case (readtype)
                3'b010, 3'b011: req_size = SZ_BYTE;
                3'b100:         req_size = SZ_DBL;
                default:        req_size = SZ_WORD;
            endcase
            req_signed = (readtype == 3'b000) || (readtype == 3'b010);
        end
        req_bad = (!is_store && (readtype > 3'b100))
               || ((req_size == SZ_WORD) && (addr[1:0] != 2'b00))
               || ((req_size == SZ_DBL) && (addr[2:0] != 3'b000));
    end

    assign beat_ack = mem_req && mem_ack;
    assign timeout  = (ACK_TIMEOUT != 0) && mem_req && !mem_ack && (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            lo_q     <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            err_q    <= err_d;
            lo_q     <= lo_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = req_bad ? RESP : ACC_LO;
            end
            ACC_LO: begin
                if (beat_ack)     state_d = (size_q == SZ_DBL) ? ACC_HI : RESP;
                else if (timeout) state_d = RESP;
            end
            ACC_HI: begin
                if (beat_ack || timeout) state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: command latch, watchdog, load assembly and extension.
    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        size_d     = size_q;
        signed_d   = signed_q;
        err_d      = err_q;
        lo_d       = lo_q;
        rdata_d    = rdata_q;
        cnt_d      = '0;
        lane_shift = mem_rdata >> {addr_q[1:0], 3'b000};
        lane_byte  = lane_shift[7:0];
        if (state_q == IDLE && start) begin
            addr_d   = addr;
            wdata_d  = wdata;
            write_d  = is_store;
            size_d   = req_size;
            signed_d = req_signed;
            err_d    = req_bad;
        end
        if (mem_req && (state_d == state_q) && (ACK_TIMEOUT != 0)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (timeout) err_d = 1'b1;
        if (beat_ack && !write_q) begin
            if (state_q == ACC_HI) begin
                rdata_d = {mem_rdata, lo_q};
            end else begin
                case (size_q)
                    SZ_BYTE: rdata_d = signed_q ? {{56{lane_byte[7]}}, lane_byte} : {56'd0, lane_byte};
                    SZ_WORD: rdata_d = signed_q ? {{32{mem_rdata[31]}}, mem_rdata} : {32'd0, mem_rdata};
                    default: lo_d    = mem_rdata;
                endcase
            end
        end
    end

    always_comb begin
        base_addr = {addr_q[31:2], 2'b00};
        mem_req   = (state_q == ACC_LO) || (state_q == ACC_HI);
        busy      = (state_q != IDLE);
        done      = (state_q == RESP);
        err       = (state_q == RESP) && err_q;
        mem_we    = mem_req && write_q;
        mem_addr  = 32'd0;
        mem_be    = 4'b0000;
        mem_wdata = 32'd0;
        if (state_q == ACC_LO) mem_addr = base_addr;
        if (state_q == ACC_HI) mem_addr = base_addr + 32'd4;
        if (mem_req) mem_be = (size_q == SZ_BYTE) ? (4'b0001 << addr_q[1:0]) : 4'b1111;
        if (mem_we) begin
            if (size_q == SZ_BYTE)       mem_wdata = {4{wdata_q[7:0]}};
            else if (state_q == ACC_HI)  mem_wdata = wdata_q[63:32];
            else                         mem_wdata = wdata_q[31:0];
        end
    end

    assign rdata     = rdata_q;
    assign dbg_state = state_q;

endmodule
